// File: rtl/ex_stage_mdu_if.sv
// Execute-stage bus: ID/EX payload, MEM/WB forwarding sources and the EX/MEM-facing results.
// The pipeline side drives through master; ex_stage_mdu consumes it through slave.
interface ex_stage_mdu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    // Handshake: an instruction is accepted by EX on a cycle where valid_i=1 and stall_o=0;
    // while stall_o=1 upstream holds every payload field stable and EX/MEM must take a bubble.
    logic                  valid_i, flush_i;
    logic [DATA_WIDTH-1:0] pc, pc4, opr_a, opr_b, imm;
    logic                  opr_a_sel, opr_b_sel;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [3:0]            aluop;
    logic                  md_en;
    logic [2:0]            mduop, cfuop;
    logic                  rf_en, dm_en;
    logic [1:0]            wb_sel;
    logic [2:0]            lsuop;
    logic                  mem_rf_en;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] mem_opr_res;
    logic                  wb_rf_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [DATA_WIDTH-1:0] opr_res, store_data, pc4_o, br_target;
    logic [REG_ADDR_W-1:0] rd_o;
    logic                  rf_en_o, dm_en_o, br_taken, stall_o;
    logic [1:0]            wb_sel_o;
    logic [2:0]            lsuop_o;
    logic [1:0]            mdu_state;

    modport master (
        output valid_i, flush_i, pc, pc4, opr_a, opr_b, imm, opr_a_sel, opr_b_sel,
               rs1, rs2, rd, aluop, md_en, mduop, cfuop, rf_en, dm_en, wb_sel, lsuop,
               mem_rf_en, mem_rd, mem_opr_res, wb_rf_en, wb_rd, wb_data,
        input  opr_res, store_data, rd_o, pc4_o, rf_en_o, dm_en_o, wb_sel_o, lsuop_o,
               br_taken, br_target, stall_o, mdu_state
    );

    modport slave (
        input  valid_i, flush_i, pc, pc4, opr_a, opr_b, imm, opr_a_sel, opr_b_sel,
               rs1, rs2, rd, aluop, md_en, mduop, cfuop, rf_en, dm_en, wb_sel, lsuop,
               mem_rf_en, mem_rd, mem_opr_res, wb_rf_en, wb_rd, wb_data,
        output opr_res, store_data, rd_o, pc4_o, rf_en_o, dm_en_o, wb_sel_o, lsuop_o,
               br_taken, br_target, stall_o, mdu_state
    );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding, ALU, branch resolve and a radix-2 iterative RV32M unit.
// Define MDU_FAST_MUL_EN to make multiplies single-cycle combinational.
module ex_stage_mdu #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic            clk,
    input logic            rst,
    ex_stage_mdu_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [W-1:0]  acc, lo, opb_q;
    logic          is_div_q, neg_res_q, sel_hi_q;

    logic [W-1:0]  fwd_a, fwd_b, alu_a, alu_b, alu_res, res, md_res, special_res;
    logic [W-1:0]  mag_a, mag_b, raw, mul_hi_neg;
    logic [CW-1:0] shamt;
    logic          br_cond, is_div, a_signed, b_signed, sa, sb;
    logic          div_zero, div_ovf, special, start, stall, live;
    logic [W:0]    trial, mul_sum;

    // MEM is assigned last so it overrides a simultaneous WB match.
    always_comb begin
        fwd_a = bus.opr_a;
        fwd_b = bus.opr_b;
        if (bus.wb_rf_en && bus.wb_rd == bus.rs1 && bus.rs1 != '0) fwd_a = bus.wb_data;
        if (bus.wb_rf_en && bus.wb_rd == bus.rs2 && bus.rs2 != '0) fwd_b = bus.wb_data;
        if (bus.mem_rf_en && bus.mem_rd == bus.rs1 && bus.rs1 != '0) fwd_a = bus.mem_opr_res;
        if (bus.mem_rf_en && bus.mem_rd == bus.rs2 && bus.rs2 != '0) fwd_b = bus.mem_opr_res;
    end

    assign alu_a = bus.opr_a_sel ? bus.pc  : fwd_a;
    assign alu_b = bus.opr_b_sel ? bus.imm : fwd_b;
    assign shamt = alu_b[CW-1:0];

    always_comb begin
        case (bus.aluop)
            ALU_ADD:   alu_res = alu_a + alu_b;
            ALU_SUB:   alu_res = alu_a - alu_b;
            ALU_SLL:   alu_res = alu_a << shamt;
            ALU_SLT:   alu_res = {{(W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:  alu_res = {{(W-1){1'b0}}, alu_a < alu_b};
            ALU_XOR:   alu_res = alu_a ^ alu_b;
            ALU_SRL:   alu_res = alu_a >> shamt;
            ALU_SRA:   alu_res = $signed(alu_a) >>> shamt;
            ALU_OR:    alu_res = alu_a | alu_b;
            ALU_AND:   alu_res = alu_a & alu_b;
            ALU_PASSB: alu_res = alu_b;
            default:   alu_res = '0;
        endcase
    end

    // cfuop: 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 unconditional jump, 0 no branch.
    always_comb begin
        case (bus.cfuop)
            3'd1:    br_cond = (fwd_a == fwd_b);
            3'd2:    br_cond = (fwd_a != fwd_b);
            3'd3:    br_cond = ($signed(fwd_a) < $signed(fwd_b));
            3'd4:    br_cond = !($signed(fwd_a) < $signed(fwd_b));
            3'd5:    br_cond = (fwd_a < fwd_b);
            3'd6:    br_cond = !(fwd_a < fwd_b);
            3'd7:    br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    // The datapath works on magnitudes; the sign is reapplied once in DONE.
    assign is_div   = bus.mduop[2];
    assign a_signed = is_div ? !bus.mduop[0] : (bus.mduop[1:0] != 2'd3);
    assign b_signed = is_div ? !bus.mduop[0] : !bus.mduop[1];
    assign sa       = a_signed & fwd_a[W-1];
    assign sb       = b_signed & fwd_b[W-1];
    assign mag_a    = sa ? -fwd_a : fwd_a;
    assign mag_b    = sb ? -fwd_b : fwd_b;
    assign div_zero = is_div && fwd_b == '0;
    assign div_ovf  = is_div && !bus.mduop[0] && fwd_a == MIN && fwd_b == '1;
    assign special  = div_zero | div_ovf;
    assign start    = (state == IDLE) && bus.valid_i && bus.md_en && !bus.flush_i &&
                      (is_div || !FAST_MUL) && !special;

    always_comb begin
        if (div_zero) special_res = bus.mduop[1] ? fwd_a : '1;
        else          special_res = bus.mduop[1] ? '0 : MIN;
    end

    assign trial   = {acc, lo[W-1]} - {1'b0, opb_q};
    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb_q} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            lo        <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            sel_hi_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= BUSY;
                    count     <= '0;
                    acc       <= '0;
                    lo        <= is_div ? mag_a : mag_b;
                    opb_q     <= is_div ? mag_b : mag_a;
                    is_div_q  <= is_div;
                    neg_res_q <= (is_div && bus.mduop[1]) ? sa : (sa ^ sb);
                    sel_hi_q  <= is_div ? bus.mduop[1] : (bus.mduop[1:0] != 2'd0);
                end
                BUSY: if (bus.flush_i) begin
                    state <= IDLE;
                end else begin
                    count <= count + CW'(1);
                    if (is_div_q) begin
                        if (!trial[W]) begin
                            acc <= trial[W-1:0];
                            lo  <= {lo[W-2:0], 1'b1};
                        end else begin
                            acc <= {acc[W-2:0], lo[W-1]};
                            lo  <= {lo[W-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[W:1];
                        lo  <= {mul_sum[0], lo[W-1:1]};
                    end
                    if (count == CW'(W-1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Negating a 2W product: the high half only takes the +1 carry when the low half is zero.
    assign raw        = sel_hi_q ? acc : lo;
    assign mul_hi_neg = ~acc + W'(lo == '0);

    always_comb begin
        if (!is_div_q && sel_hi_q) md_res = neg_res_q ? mul_hi_neg : acc;
        else                       md_res = neg_res_q ? -raw : raw;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
    assign fast_prod = (sa ^ sb) ? -fast_mag : fast_mag;
`endif

    always_comb begin
        res = alu_res;
        if (state == DONE) begin
            res = md_res;
        end else if (state == IDLE && bus.md_en) begin
            if (special) res = special_res;
`ifdef MDU_FAST_MUL_EN
            else if (!is_div) res = (bus.mduop[1:0] == 2'd0) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`endif
        end
    end

    assign stall = !rst && bus.valid_i && ((state == BUSY) || start);
    assign live  = !rst && bus.valid_i && !bus.flush_i && !stall;

    assign bus.stall_o    = stall;
    assign bus.rf_en_o    = live & bus.rf_en;
    assign bus.dm_en_o    = live & bus.dm_en;
    assign bus.br_taken   = live & br_cond;
    assign bus.opr_res    = rst ? '0 : res;
    assign bus.store_data = rst ? '0 : fwd_b;
    assign bus.br_target  = rst ? '0 : alu_res;
    assign bus.rd_o       = bus.rd;
    assign bus.pc4_o      = bus.pc4;
    assign bus.wb_sel_o   = bus.wb_sel;
    assign bus.lsuop_o    = bus.lsuop;
    assign bus.mdu_state  = state;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: arithmetic reference model, writeback scoreboard,
// literal expectations for ALU, forwarding, branch, M-ops, flush and reset.
`timescale 1ns/1ps
module tb_ex_stage_mdu;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_STALL = 0;
`else
    localparam int MUL_STALL = W + 1;
`endif
    localparam int DIV_STALL = W + 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] exp_q[$];

    ex_stage_mdu_if #(.DATA_WIDTH(W), .REG_ADDR_W(5)) bus ();
    ex_stage_mdu #(.DATA_WIDTH(W), .REG_ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] t;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        t  = 64'd0;
        case (op)
            3'd0: begin t = sa * sb; return t[31:0]; end
            3'd1: begin t = sa * sb; return t[63:32]; end
            3'd2: begin t = sa * longint'(ub); return t[63:32]; end
            3'd3: begin t = ua * ub; return t[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; t = sa / sb; return t[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; t = ua / ub; return t[31:0]; end
            3'd6: begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
            default: begin if (b == 0) return a; t = ua % ub; return t[31:0]; end
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  return $signed(a) >>> b[4:0];
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Value an instruction sees for register rs, given the bypass sources on the bus.
    function automatic logic [31:0] ref_opnd(input logic [4:0] rs, input logic [31:0] regval);
        if (rs != 0 && bus.mem_rf_en && bus.mem_rd == rs) return bus.mem_opr_res;
        if (rs != 0 && bus.wb_rf_en && bus.wb_rd == rs) return bus.wb_data;
        return regval;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every writeback leaving EX is matched against the model's queue.
    always @(negedge clk) begin
        if (!rst && bus.valid_i && bus.rf_en_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL writeback: unexpected rf_en_o with opr_res=0x%08h, expected none", bus.opr_res);
            end else begin
                chk("model opr_res", bus.opr_res, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        bus.valid_i = 0; bus.flush_i = 0; bus.pc = 0; bus.pc4 = 0; bus.opr_a = 0; bus.opr_b = 0;
        bus.imm = 0; bus.opr_a_sel = 0; bus.opr_b_sel = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0;
        bus.aluop = 0; bus.md_en = 0; bus.mduop = 0; bus.cfuop = 0; bus.rf_en = 0; bus.dm_en = 0;
        bus.wb_sel = 0; bus.lsuop = 0; bus.mem_rf_en = 0; bus.mem_rd = 0; bus.mem_opr_res = 0;
        bus.wb_rf_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic start_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        clear_inputs();
        bus.valid_i = 1; bus.md_en = 1; bus.mduop = op; bus.opr_a = a; bus.opr_b = b;
        bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.rd = 5'd3; bus.rf_en = 1; bus.pc4 = 32'h104;
    endtask

    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int exp_stall, input string name);
        int stalls = 0, bubble_bad = 0;
        logic done = 0, wb = 0;
        logic [31:0] res = 0;
        start_md(op, a, b);
        exp_q.push_back(ref_mdu(op, a, b));
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (bus.stall_o) begin
                stalls++;
                if (bus.rf_en_o) bubble_bad++;
                if (stalls >= 2) begin
                    // operands are latched by now; bypass traffic must not disturb the op
                    bus.mem_rf_en = 1; bus.mem_rd = 5'd1; bus.mem_opr_res = $urandom;
                    bus.wb_rf_en = 1;  bus.wb_rd = 5'd2;  bus.wb_data = $urandom;
                end
            end else begin
                res  = bus.opr_res;
                wb   = bus.rf_en_o;
                done = 1;
            end
        end
        chk({name, " completes"}, 32'(done), 32'd1);
        chk({name, " stall cycles"}, 32'(stalls), 32'(exp_stall));
        chk({name, " rf_en_o in stall"}, 32'(bubble_bad), 32'd0);
        chk({name, " result"}, res, lit);
        chk({name, " rf_en_o done"}, 32'(wb), 32'd1);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic men, input logic [4:0] mrd, input logic [31:0] mval,
                          input logic wen, input logic [4:0] wrd, input logic [31:0] wval,
                          input logic [31:0] lit, input string name);
        logic [31:0] oa, ob;
        @(posedge clk); #1;
        clear_inputs();
        bus.valid_i = 1; bus.aluop = op; bus.opr_a = a; bus.opr_b = b; bus.rs1 = r1; bus.rs2 = r2;
        bus.rd = 5'd9; bus.rf_en = 1; bus.pc4 = 32'h204;
        bus.mem_rf_en = men; bus.mem_rd = mrd; bus.mem_opr_res = mval;
        bus.wb_rf_en = wen;  bus.wb_rd = wrd;  bus.wb_data = wval;
        oa = ref_opnd(r1, a);
        ob = ref_opnd(r2, b);
        exp_q.push_back(ref_alu(op, oa, ob));
        @(negedge clk);
        chk({name, " result"}, bus.opr_res, lit);
        chk({name, " store_data"}, bus.store_data, ob);
        chk({name, " stall_o"}, 32'(bus.stall_o), 32'd0);
        chk({name, " rd_o"}, 32'(bus.rd_o), 32'd9);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_inputs();
        rst = 1;
        bus.valid_i = 1; bus.rf_en = 1; bus.dm_en = 1; bus.cfuop = 3'd7;
        bus.opr_a = 32'h11; bus.opr_b = 32'h22; bus.md_en = 1; bus.mduop = 3'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall_o", 32'(bus.stall_o), 32'd0);
        chk("rst rf_en_o", 32'(bus.rf_en_o), 32'd0);
        chk("rst dm_en_o", 32'(bus.dm_en_o), 32'd0);
        chk("rst br_taken", 32'(bus.br_taken), 32'd0);
        chk("rst opr_res", bus.opr_res, 32'd0);
        chk("rst store_data", bus.store_data, 32'd0);
        chk("rst br_target", bus.br_target, 32'd0);
        chk("rst state", 32'(bus.mdu_state), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();

        // ALU, no bypass
        alu_op(4'd0, 32'h11, 32'h22, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 32'h33, "add");
        alu_op(4'd1, 32'd5, 32'd7, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE, "sub");
        alu_op(4'd3, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 32'd1, "slt");
        alu_op(4'd4, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 32'd0, "sltu");
        alu_op(4'd7, 32'h80000000, 32'd4, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 32'hF8000000, "sra");
        alu_op(4'd5, 32'hF0F0, 32'h0FF0, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 32'hFF00, "xor");

        // bypass priority and x0
        alu_op(4'd0, 32'h100, 32'h20, 5'd5, 5'd2, 1, 5'd5, 32'hA, 1, 5'd5, 32'hB, 32'h2A, "fwd mem wins");
        alu_op(4'd0, 32'h100, 32'h20, 5'd0, 5'd2, 1, 5'd0, 32'hA, 1, 5'd0, 32'hB, 32'h120, "fwd x0");
        alu_op(4'd0, 32'h100, 32'h20, 5'd5, 5'd2, 1, 5'd6, 32'hA, 1, 5'd5, 32'hB, 32'h2B, "fwd wb only");
        alu_op(4'd0, 32'h1, 32'h2, 5'd1, 5'd7, 0, 0, 0, 1, 5'd7, 32'h55, 32'h56, "fwd rs2 wb");

        // branches: target from pc+imm, compare on bypassed registers
        @(posedge clk); #1;
        clear_inputs();
        bus.valid_i = 1; bus.cfuop = 3'd1; bus.opr_a_sel = 1; bus.opr_b_sel = 1;
        bus.pc = 32'h2000; bus.imm = 32'h80; bus.opr_a = 32'd1; bus.opr_b = 32'd2;
        bus.rs1 = 5'd5; bus.rs2 = 5'd6;
        bus.mem_rf_en = 1; bus.mem_rd = 5'd5; bus.mem_opr_res = 32'hA;
        bus.wb_rf_en = 1;  bus.wb_rd = 5'd6;  bus.wb_data = 32'hA;
        @(negedge clk);
        chk("beq fwd taken", 32'(bus.br_taken), 32'd1);
        chk("beq target", bus.br_target, 32'h2080);
        chk("beq rf_en_o", 32'(bus.rf_en_o), 32'd0);
        bus.cfuop = 3'd2;
        #1 chk("bne fwd not taken", 32'(bus.br_taken), 32'd0);
        bus.cfuop = 3'd1; bus.flush_i = 1;
        #1 chk("beq flushed", 32'(bus.br_taken), 32'd0);
        bus.flush_i = 0; bus.valid_i = 0;
        #1 chk("beq invalid", 32'(bus.br_taken), 32'd0);
        bus.valid_i = 1; bus.cfuop = 3'd3; bus.mem_rf_en = 0; bus.wb_rf_en = 0;
        bus.opr_a = 32'hFFFFFFFF; bus.opr_b = 32'd1;
        #1 chk("blt signed taken", 32'(bus.br_taken), 32'd1);
        bus.cfuop = 3'd5;
        #1 chk("bltu not taken", 32'(bus.br_taken), 32'd0);

        // divide / remainder
        do_md(3'd5, 32'd100, 32'd7, 32'd14, DIV_STALL, "divu 100/7");
        do_md(3'd7, 32'd100, 32'd7, 32'd2, DIV_STALL, "remu 100/7");
        do_md(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_STALL, "div -7/2");
        do_md(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_STALL, "rem -7/2");
        do_md(3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_STALL, "div 7/-2");
        do_md(3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, DIV_STALL, "rem 7/-2");
        do_md(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "div 5/0");
        do_md(3'd6, 32'd5, 32'd0, 32'd5, 0, "rem 5/0");
        do_md(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "divu 5/0");
        do_md(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div ovf");
        do_md(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, "rem ovf");
        do_md(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, DIV_STALL, "divu big/ones");

        // multiply
        do_md(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_STALL, "mulh min*min");
        do_md(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, MUL_STALL, "mul -1*-1");
        do_md(3'd3, 32'hFFFFFFFF, 32'd2, 32'd1, MUL_STALL, "mulhu ones*2");
        do_md(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_STALL, "mulhsu -1*2");
        do_md(3'd1, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, MUL_STALL, "mulh -2^16*2^16");
        do_md(3'd0, 32'h12345678, 32'h10, 32'h23456780, MUL_STALL, "mul shift");

        // flush in BUSY cycle 10
        start_md(3'd5, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 bus.flush_i = 1;
        @(negedge clk);
        chk("flush cycle stall_o", 32'(bus.stall_o), 32'd1);
        chk("flush cycle rf_en_o", 32'(bus.rf_en_o), 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("after flush stall_o", 32'(bus.stall_o), 32'd0);
        chk("after flush state", 32'(bus.mdu_state), 32'd0);
        do_md(3'd5, 32'd9, 32'd3, 32'd3, DIV_STALL, "divu 9/3 after flush");

        // reset in BUSY cycle 5
        start_md(3'd5, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("mid rst stall_o", 32'(bus.stall_o), 32'd0);
        chk("mid rst rf_en_o", 32'(bus.rf_en_o), 32'd0);
        chk("mid rst opr_res", bus.opr_res, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();
        @(negedge clk);
        chk("after rst stall_o", 32'(bus.stall_o), 32'd0);
        chk("after rst rf_en_o", 32'(bus.rf_en_o), 32'd0);
        chk("after rst state", 32'(bus.mdu_state), 32'd0);
        do_md(3'd0, 32'd6, 32'd7, 32'd42, MUL_STALL, "mul 6*7 after rst");

        repeat (3) @(posedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
